// File: rtl/n1_pf_pkg.sv
// Shared types and width helpers for the N1 program-bus prefetch front end.
package n1_pf_pkg;

    typedef enum logic [1:0] {
        PF_FETCH = 2'd0,
        PF_DRAIN = 2'd1,
        PF_ERROR = 2'd2
    } pf_state_e;

    typedef enum logic [1:0] {
        RSN_REDIRECT = 2'd0,
        RSN_RETRY    = 2'd1,
        RSN_ERROR    = 2'd2
    } pf_reason_e;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/n1_pf_fifo.sv
// Synchronous prefetch queue with flush; head is read straight from the register array.
module n1_pf_fifo
    import n1_pf_pkg::*;
#(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      sync_rst_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    input  logic [WIDTH-1:0]          wdata_i,
    output logic [WIDTH-1:0]          head_o,
    output logic                      valid_o,
    output logic [cnt_w(DEPTH)-1:0]   fill_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [FW-1:0]    fill_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & (fill_q != FW'(DEPTH));
    assign do_pop  = pop_i & (fill_q != '0);

    always_ff @(posedge clk_i) begin
        if (sync_rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            fill_q <= fill_q + FW'(do_push) - FW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by fill_q alone.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_i && !flush_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (fill_q != '0);
    assign fill_o  = fill_q;

endmodule

// File: rtl/n1_fc_prefetch.sv
// Pipelined Wishbone program fetch with outstanding-access tracking, redirect/retry/error
// draining and a prefetch queue feeding the IR.
module n1_fc_prefetch
    import n1_pf_pkg::*;
#(
    parameter int unsigned PBUS_AADR_WIDTH = 14,
    parameter int unsigned PBUS_DAT_WIDTH  = 16,
    parameter int unsigned PF_DEPTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned RESET_ADR       = 0
) (
    input  logic                                clk_i,
    input  logic                                sync_rst_i,
    output logic                                pbus_cyc_o,
    output logic                                pbus_stb_o,
    output logic [PBUS_AADR_WIDTH-1:0]          pbus_adr_o,
    input  logic                                pbus_ack_i,
    input  logic                                pbus_err_i,
    input  logic                                pbus_rty_i,
    input  logic                                pbus_stall_i,
    input  logic [PBUS_DAT_WIDTH-1:0]           pbus_dat_i,
    input  logic                                fc2pf_jmp_i,
    input  logic [PBUS_AADR_WIDTH-1:0]          fc2pf_jmp_adr_i,
    input  logic                                fc2pf_halt_i,
    output logic                                pf2ir_valid_o,
    output logic [PBUS_DAT_WIDTH-1:0]           pf2ir_dat_o,
    output logic [PBUS_AADR_WIDTH-1:0]          pf2ir_adr_o,
    input  logic                                ir2pf_ready_i,
    output logic                                pf2excpt_buserr_o,
    output logic [PBUS_AADR_WIDTH-1:0]          pf2excpt_buserr_adr_o,
    output logic [1:0]                          prb_pf_state_o,
    output logic [cnt_w(PF_DEPTH)-1:0]          prb_pf_fill_o,
    output logic [cnt_w(MAX_OUTSTANDING)-1:0]   prb_pf_outstanding_o
);

    localparam int unsigned AW = PBUS_AADR_WIDTH;
    localparam int unsigned DW = PBUS_DAT_WIDTH;
    localparam int unsigned FW = cnt_w(PF_DEPTH);
    localparam int unsigned OW = cnt_w(MAX_OUTSTANDING);
    localparam int unsigned SW = ((FW > OW) ? FW : OW) + 1;
    localparam logic [AW-1:0] RST_ADR = AW'(RESET_ADR);

    pf_state_e     state_q,      state_d;
    pf_reason_e    reason_q,     reason_d;
    logic [AW-1:0] fetch_adr_q,  fetch_adr_d;
    logic [AW-1:0] rsp_adr_q,    rsp_adr_d;
    logic [OW-1:0] outs_q,       outs_d;
    logic          buserr_q,     buserr_d;
    logic [AW-1:0] buserr_adr_q, buserr_adr_d;

    logic [FW-1:0]    fill;
    logic [AW+DW-1:0] head;
    logic             stb_c;
    logic             accept;
    logic             dec;
    logic             push;
    logic             pop;
    logic             flush;

    // Queue space for every in-flight access is reserved before it is issued.
    assign stb_c = !sync_rst_i && (state_q == PF_FETCH) && !fc2pf_halt_i
                 && (outs_q < OW'(MAX_OUTSTANDING))
                 && ((SW'(fill) + SW'(outs_q)) < SW'(PF_DEPTH));
    assign accept = stb_c & !pbus_stall_i;
    assign dec    = (pbus_ack_i | pbus_err_i | pbus_rty_i) & (outs_q != '0);
    assign pop    = pf2ir_valid_o & ir2pf_ready_i & !fc2pf_jmp_i;

    always_comb begin
        state_d      = state_q;
        reason_d     = reason_q;
        fetch_adr_d  = accept ? fetch_adr_q + AW'(1) : fetch_adr_q;
        rsp_adr_d    = rsp_adr_q;
        outs_d       = outs_q + OW'(accept) - OW'(dec);
        buserr_d     = 1'b0;
        buserr_adr_d = buserr_adr_q;
        push         = 1'b0;
        flush        = 1'b0;
        if (fc2pf_jmp_i) begin
            // Redirect wins everywhere; stale responses still in flight are drained.
            flush       = 1'b1;
            fetch_adr_d = fc2pf_jmp_adr_i;
            rsp_adr_d   = fc2pf_jmp_adr_i;
            reason_d    = RSN_REDIRECT;
            state_d     = (outs_d != '0) ? PF_DRAIN : PF_FETCH;
        end else begin
            case (state_q)
                PF_FETCH: begin
                    if (pbus_err_i && dec) begin
                        buserr_adr_d = rsp_adr_q;
                        reason_d     = RSN_ERROR;
                        state_d      = PF_DRAIN;
                    end else if (pbus_rty_i && dec) begin
                        reason_d = RSN_RETRY;
                        state_d  = PF_DRAIN;
                    end else if (pbus_ack_i && dec) begin
                        push      = 1'b1;
                        rsp_adr_d = rsp_adr_q + AW'(1);
                    end
                end
                PF_DRAIN: begin
                    if (outs_d == '0) begin
                        case (reason_q)
                            RSN_RETRY: begin
                                fetch_adr_d = rsp_adr_q;
                                state_d     = PF_FETCH;
                            end
                            RSN_ERROR: begin
                                buserr_d = 1'b1;
                                state_d  = PF_ERROR;
                            end
                            default: state_d = PF_FETCH;
                        endcase
                    end
                end
                PF_ERROR: state_d = PF_ERROR;
                default:  state_d = PF_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q      <= PF_FETCH;
            reason_q     <= RSN_REDIRECT;
            fetch_adr_q  <= RST_ADR;
            rsp_adr_q    <= RST_ADR;
            outs_q       <= '0;
            buserr_q     <= 1'b0;
            buserr_adr_q <= '0;
        end else begin
            state_q      <= state_d;
            reason_q     <= reason_d;
            fetch_adr_q  <= fetch_adr_d;
            rsp_adr_q    <= rsp_adr_d;
            outs_q       <= outs_d;
            buserr_q     <= buserr_d;
            buserr_adr_q <= buserr_adr_d;
        end
    end

    n1_pf_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (PF_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .push_i     (push),
        .pop_i      (pop),
        .flush_i    (flush),
        .wdata_i    ({rsp_adr_q, pbus_dat_i}),
        .head_o     (head),
        .valid_o    (pf2ir_valid_o),
        .fill_o     (fill)
    );

    assign pbus_stb_o            = stb_c;
    assign pbus_cyc_o            = !sync_rst_i && (stb_c || (outs_q != '0));
    assign pbus_adr_o            = fetch_adr_q;
    assign pf2ir_adr_o           = head[AW+DW-1:DW];
    assign pf2ir_dat_o           = head[DW-1:0];
    assign pf2excpt_buserr_o     = buserr_q;
    assign pf2excpt_buserr_adr_o = buserr_adr_q;
    assign prb_pf_state_o        = state_q;
    assign prb_pf_fill_o         = fill;
    assign prb_pf_outstanding_o  = outs_q;

endmodule

// File: tb/tb_n1_fc_prefetch.sv
// Directed bench for n1_fc_prefetch with a small pipelined Wishbone slave model.
module tb_n1_fc_prefetch;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic        cyc, stb, ack, err, rty, stall;
    logic [13:0] adr;
    logic [15:0] dat;
    logic        jmp, halt, ready;
    logic [13:0] jmp_adr;
    logic        valid;
    logic [15:0] ir_dat;
    logic [13:0] ir_adr;
    logic        buserr;
    logic [13:0] buserr_adr;
    logic [1:0]  st;
    logic [2:0]  fill;
    logic [1:0]  outs;

    int n_checks = 0;
    int n_errors = 0;

    logic        slave_on, err_arm, rty_arm;
    logic [13:0] err_adr, rty_adr;
    logic [13:0] pend[$];
    logic [13:0] acc_q[$];
    logic [13:0] pop_adr_q[$];
    logic [15:0] pop_dat_q[$];
    int          max_outs;
    int          buserr_cnt;

    always #5 clk = ~clk;

    n1_fc_prefetch dut (
        .clk_i                 (clk),
        .sync_rst_i            (sync_rst),
        .pbus_cyc_o            (cyc),
        .pbus_stb_o            (stb),
        .pbus_adr_o            (adr),
        .pbus_ack_i            (ack),
        .pbus_err_i            (err),
        .pbus_rty_i            (rty),
        .pbus_stall_i          (stall),
        .pbus_dat_i            (dat),
        .fc2pf_jmp_i           (jmp),
        .fc2pf_jmp_adr_i       (jmp_adr),
        .fc2pf_halt_i          (halt),
        .pf2ir_valid_o         (valid),
        .pf2ir_dat_o           (ir_dat),
        .pf2ir_adr_o           (ir_adr),
        .ir2pf_ready_i         (ready),
        .pf2excpt_buserr_o     (buserr),
        .pf2excpt_buserr_adr_o (buserr_adr),
        .prb_pf_state_o        (st),
        .prb_pf_fill_o         (fill),
        .prb_pf_outstanding_o  (outs)
    );

    function automatic logic [15:0] fdat(input logic [13:0] a);
        return {2'b00, a} ^ 16'hC3A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive slave response at negedge, sample before posedge, book-keep after it.
    task automatic step();
        logic        acc, trm, popv, e_now, r_now;
        logic [13:0] a_smp, pa;
        logic [15:0] pd;
        ack = 1'b0; err = 1'b0; rty = 1'b0; dat = '0;
        if (slave_on && pend.size() > 0) begin
            if (err_arm && pend[0] == err_adr)      err = 1'b1;
            else if (rty_arm && pend[0] == rty_adr) rty = 1'b1;
            else begin
                ack = 1'b1;
                dat = fdat(pend[0]);
            end
        end
        #1;
        acc   = stb & ~stall;
        trm   = ack | err | rty;
        e_now = err;
        r_now = rty;
        a_smp = adr;
        popv  = valid & ready & ~jmp;
        pa    = ir_adr;
        pd    = ir_dat;
        if (int'(outs) > max_outs) max_outs = int'(outs);
        if (buserr) buserr_cnt++;
        @(posedge clk);
        if (sync_rst) pend.delete();
        else begin
            if (trm) begin
                void'(pend.pop_front());
                if (e_now) err_arm = 1'b0;
                if (r_now) rty_arm = 1'b0;
            end
            if (acc) begin
                pend.push_back(a_smp);
                acc_q.push_back(a_smp);
            end
            if (popv) begin
                pop_adr_q.push_back(pa);
                pop_dat_q.push_back(pd);
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        acc_q.delete();
        pop_adr_q.delete();
        pop_dat_q.delete();
        max_outs   = 0;
        buserr_cnt = 0;
    endtask

    // Leaves reset asserted so the caller can inspect the reset state.
    task automatic reset_dut();
        sync_rst = 1'b1;
        jmp = 1'b0; jmp_adr = '0; halt = 1'b0; ready = 1'b0; stall = 1'b0;
        slave_on = 1'b0; err_arm = 1'b0; rty_arm = 1'b0;
        repeat (2) step();
        clear_logs();
    endtask

    initial begin
        sync_rst = 1'b1; ack = 1'b0; err = 1'b0; rty = 1'b0; dat = '0;
        err_adr = '0; rty_adr = '0;
        @(negedge clk);

        // Reset state
        reset_dut();
        check("rst_cyc", cyc, 0);
        check("rst_stb", stb, 0);
        check("rst_valid", valid, 0);
        check("rst_buserr", buserr, 0);
        check("rst_buserr_adr", buserr_adr, 0);
        check("rst_fill", fill, 0);
        check("rst_outs", outs, 0);
        check("rst_state", st, 0);
        check("rst_adr", adr, 0);

        // 1: streaming fetch, ack one cycle after accept
        sync_rst = 1'b0; ready = 1'b1; slave_on = 1'b1;
        repeat (14) step();
        check("t1_acc_cnt_ge8", acc_q.size() >= 8, 1);
        check("t1_pop_cnt_ge8", pop_adr_q.size() >= 8, 1);
        if (acc_q.size() >= 8 && pop_adr_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t1_acc%0d", i), acc_q[i], i);
                check($sformatf("t1_pop_adr%0d", i), pop_adr_q[i], i);
                check($sformatf("t1_pop_dat%0d", i), pop_dat_q[i], fdat(14'(i)));
            end
        end
        check("t1_max_outs", max_outs, 1);

        // 2: IR stalled, queue fills to depth; one pop frees one slot
        reset_dut();
        sync_rst = 1'b0; ready = 1'b0; slave_on = 1'b1;
        repeat (10) step();
        check("t2_acc_cnt", acc_q.size(), 4);
        check("t2_fill", fill, 4);
        check("t2_stb", stb, 0);
        check("t2_valid", valid, 1);
        check("t2_head_adr", ir_adr, 0);
        check("t2_head_dat", ir_dat, fdat(14'd0));
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("t2_fill_pop", fill, 3);
        check("t2_stb_refill", stb, 1);
        check("t2_adr_refill", adr, 4);
        repeat (5) step();
        check("t2_acc_cnt2", acc_q.size(), 5);
        check("t2_acc4", (acc_q.size() == 5) ? acc_q[4] : 14'h3FFF, 4);
        check("t2_fill2", fill, 4);
        check("t2_stb2", stb, 0);
        check("t2_head_adr2", ir_adr, 1);

        // 3: redirect with two accesses in flight
        reset_dut();
        sync_rst = 1'b0; halt = 1'b1; jmp = 1'b1; jmp_adr = 14'd8;
        step();
        jmp = 1'b0; halt = 1'b0;
        repeat (2) step();
        check("t3_outs2", outs, 2);
        check("t3_adr_after", adr, 10);
        check("t3_stb_full", stb, 0);
        slave_on = 1'b1; jmp = 1'b1; jmp_adr = 14'h100;
        step();
        jmp = 1'b0;
        check("t3_state_drain", st, 1);
        check("t3_fill_flushed", fill, 0);
        check("t3_stb_drain", stb, 0);
        step();
        check("t3_state_fetch", st, 0);
        check("t3_outs0", outs, 0);
        check("t3_valid0", valid, 0);
        check("t3_stb_new", stb, 1);
        check("t3_adr_new", adr, 14'h100);
        clear_logs();
        ready = 1'b1;
        repeat (4) step();
        check("t3_pop_first", (pop_adr_q.size() > 0) ? pop_adr_q[0] : 14'h3FFF, 14'h100);
        check("t3_pop_dat", (pop_dat_q.size() > 0) ? pop_dat_q[0] : 16'h0, fdat(14'h100));

        // 4: retry on adr 5 while 6 is in flight
        reset_dut();
        sync_rst = 1'b0; ready = 1'b1; slave_on = 1'b1;
        rty_arm = 1'b1; rty_adr = 14'd5;
        repeat (16) step();
        check("t4_acc_cnt_ge8", acc_q.size() >= 8, 1);
        check("t4_acc7_refetch", (acc_q.size() >= 8) ? acc_q[7] : 14'h3FFF, 5);
        check("t4_pop_cnt_ge8", pop_adr_q.size() >= 8, 1);
        if (pop_adr_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t4_pop_adr%0d", i), pop_adr_q[i], i);
                check($sformatf("t4_pop_dat%0d", i), pop_dat_q[i], fdat(14'(i)));
            end
        end

        // 5: bus error on 0x3FFF, address wrap, ERROR until redirect
        reset_dut();
        sync_rst = 1'b0; halt = 1'b1; jmp = 1'b1; jmp_adr = 14'h3FFD;
        step();
        jmp = 1'b0; halt = 1'b0; ready = 1'b1; slave_on = 1'b1;
        err_arm = 1'b1; err_adr = 14'h3FFF;
        repeat (4) step();
        check("t5_state_drain", st, 1);
        check("t5_buserr_adr", buserr_adr, 14'h3FFF);
        check("t5_buserr_early", buserr, 0);
        step();
        check("t5_state_error", st, 2);
        check("t5_buserr_pulse", buserr, 1);
        step();
        check("t5_buserr_end", buserr, 0);
        check("t5_stb_error", stb, 0);
        repeat (4) step();
        check("t5_buserr_cnt", buserr_cnt, 1);
        check("t5_acc_cnt", acc_q.size(), 4);
        check("t5_wrap", (acc_q.size() == 4) ? acc_q[3] : 14'h3FFF, 0);
        check("t5_pop_cnt", pop_adr_q.size(), 2);
        check("t5_pop1", (pop_adr_q.size() == 2) ? pop_adr_q[1] : 14'h0, 14'h3FFE);
        check("t5_state_hold", st, 2);
        jmp = 1'b1; jmp_adr = 14'h20;
        step();
        jmp = 1'b0;
        check("t5_state_exit", st, 0);
        check("t5_stb_exit", stb, 1);
        check("t5_adr_exit", adr, 14'h20);

        // 6: reset with accesses in flight and queue occupied
        reset_dut();
        sync_rst = 1'b0; ready = 1'b0; slave_on = 1'b1;
        repeat (3) step();
        slave_on = 1'b0;
        step();
        check("t6_fill_pre", fill, 2);
        check("t6_outs_pre", outs, 2);
        sync_rst = 1'b1;
        step();
        check("t6_cyc", cyc, 0);
        check("t6_stb", stb, 0);
        check("t6_valid", valid, 0);
        check("t6_fill", fill, 0);
        check("t6_outs", outs, 0);
        check("t6_adr", adr, 0);
        check("t6_state", st, 0);
        sync_rst = 1'b0;
        clear_logs();
        slave_on = 1'b1; ready = 1'b1;
        repeat (4) step();
        check("t6_acc_first", (acc_q.size() > 0) ? acc_q[0] : 14'h3FFF, 0);
        check("t6_pop_first", (pop_adr_q.size() > 0) ? pop_adr_q[0] : 14'h3FFF, 0);
        check("t6_pop_dat", (pop_dat_q.size() > 0) ? pop_dat_q[0] : 16'h0, fdat(14'd0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
